// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
package fifo_pkg;

  typedef enum logic {IDLE, BURST} arb_state_t;

  localparam int NUM_REQ_DEF   = 4;
  localparam int WIDTH_DEF     = 8;
  localparam int MAX_BURST_DEF = 4;
  localparam int CNT_W_DEF     = 16;

  // Beat counter must hold MAX_BURST-1 and still compare cleanly at MAX_BURST=1.
  function automatic int beat_width(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first eligible request at or after start.
module rr_pick
  import fifo_pkg::*;
#(
  parameter int  N  = NUM_REQ_DEF,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic [N-1:0]  mask,
  output logic          valid,
  output logic [IW-1:0] index
);

  logic [N-1:0] eligible;

  assign eligible = req & ~mask;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = 0; i < N; i++) begin
      if (!valid && eligible[(int'(start) + i) % N]) begin
        valid = 1'b1;
        index = IW'((int'(start) + i) % N);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one FIFO write port among NUM_REQ requesters.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int  NUM_REQ   = NUM_REQ_DEF,
  parameter int  WIDTH     = WIDTH_DEF,
  parameter int  MAX_BURST = MAX_BURST_DEF,
  parameter int  CNT_W     = CNT_W_DEF,
  localparam int IW        = $clog2(NUM_REQ),
  localparam int BW        = beat_width(MAX_BURST)
) (
  input  logic                     wclk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*WIDTH-1:0] data_i,
  output logic [NUM_REQ-1:0]       ack_o,
  output logic                     wen,
  output logic [WIDTH-1:0]         wdata,
  input  logic                     full,
  input  logic                     overflow,
  output logic [IW-1:0]            owner_o,
  output logic                     busy_o,
  output logic                     err_ovf_o,
  output logic [CNT_W-1:0]         wr_count_o
);

  arb_state_t      state;
  logic [IW-1:0]   ptr;
  logic [BW-1:0]   beat;

  logic            in_burst;
  logic            last_beat;
  logic            burst_done;
  logic            release_grant;
  logic [IW-1:0]   next_owner;
  logic [IW-1:0]   pick_start;
  logic [NUM_REQ-1:0] pick_mask;
  logic            pick_valid;
  logic [IW-1:0]   pick_index;

  // Reset forces the port quiet in the same cycle, not just after the edge.
  assign in_burst      = (state == BURST) && !rst;
  assign busy_o        = in_burst;
  assign wen           = in_burst && req_i[owner_o] && !full;
  assign wdata         = data_i[int'(owner_o)*WIDTH +: WIDTH];

  assign last_beat     = (beat == BW'(MAX_BURST - 1));
  assign burst_done    = wen && last_beat;
  assign release_grant = in_burst && (!req_i[owner_o] || burst_done);

  assign next_owner    = (owner_o == IW'(NUM_REQ - 1)) ? '0 : owner_o + 1'b1;
  assign pick_start    = (state == BURST) ? next_owner : ptr;

  always_comb begin
    ack_o          = '0;
    ack_o[owner_o] = wen;
  end

  // A requester that just finished a full burst sits out the same-edge re-arbitration.
  always_comb begin
    pick_mask = '0;
    if (burst_done) pick_mask[owner_o] = 1'b1;
  end

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (req_i),
    .start (pick_start),
    .mask  (pick_mask),
    .valid (pick_valid),
    .index (pick_index)
  );

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge wclk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      owner_o    <= '0;
      beat       <= '0;
      err_ovf_o  <= 1'b0;
      wr_count_o <= '0;
    end else begin
      if (overflow) err_ovf_o <= 1'b1;

      if (wen) begin
        wr_count_o <= wr_count_o + CNT_W'(1);
        beat       <= beat + 1'b1;
      end

      // A new grant's beat clear below overrides the increment above.
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state   <= BURST;
            owner_o <= pick_index;
            beat    <= '0;
          end
        end
        BURST: begin
          if (release_grant) begin
            ptr <= next_owner;
            if (pick_valid) begin
              owner_o <= pick_index;
              beat    <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: directed vector table, hand sequences, randomized run against a model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;
  localparam int CW = 16;

  logic           wclk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_i;
  logic [N*W-1:0] data_i;
  logic           full;
  logic           overflow;
  logic [N-1:0]   ack_o;
  logic           wen;
  logic [W-1:0]   wdata;
  logic [1:0]     owner_o;
  logic           busy_o;
  logic           err_ovf_o;
  logic [CW-1:0]  wr_count_o;

  int n_checks = 0;
  int n_err    = 0;

  logic [W-1:0] ds [N];

  fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB), .CNT_W(CW)) dut (
    .wclk       (wclk),
    .rst        (rst),
    .req_i      (req_i),
    .data_i     (data_i),
    .ack_o      (ack_o),
    .wen        (wen),
    .wdata      (wdata),
    .full       (full),
    .overflow   (overflow),
    .owner_o    (owner_o),
    .busy_o     (busy_o),
    .err_ovf_o  (err_ovf_o),
    .wr_count_o (wr_count_o)
  );

  always #5 wclk = ~wclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply inputs at the falling edge and let outputs settle before any check.
  task automatic drive(input logic r, input logic [N-1:0] q, input logic f, input logic o);
    @(negedge wclk);
    rst      = r;
    req_i    = q;
    full     = f;
    overflow = o;
    for (int k = 0; k < N; k++) data_i[k*W +: W] = ds[k];
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic         full;
    logic         ovf;
    logic         wen;
    logic [N-1:0] ack;
    logic         busy;
    logic [1:0]   owner;
    logic [W-1:0] wdata;
    logic         err;
  } vec_t;

  vec_t tbl [26];

  function automatic vec_t mk(input logic [N-1:0] req, input logic f, input logic o,
                              input logic e_wen, input logic [N-1:0] e_ack, input logic e_busy,
                              input logic [1:0] e_own, input logic [W-1:0] e_wd, input logic e_err);
    vec_t v;
    v.rst = 1'b0; v.req = req; v.full = f; v.ovf = o;
    v.wen = e_wen; v.ack = e_ack; v.busy = e_busy; v.owner = e_own; v.wdata = e_wd; v.err = e_err;
    return v;
  endfunction

  // ---------------- behavioural reference model ----------------
  bit          m_busy;
  int          m_owner, m_words, m_ptr;
  logic [CW-1:0] m_count;
  bit          m_err;

  function automatic int scan(input logic [N-1:0] r, input int start, input int skip);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (start + i) % N;
      if (r[k] && k != skip) return k;
    end
    return -1;
  endfunction

  task automatic model_step(output logic [N-1:0] acked);
    bit e_busy, e_wen, done;
    int w;
    e_busy = m_busy && !rst;
    e_wen  = e_busy && req_i[m_owner] && !full;
    acked  = e_wen ? N'(1 << m_owner) : '0;
    check("rnd_wen", 32'(wen), 32'(e_wen));
    check("rnd_ack", 32'(ack_o), 32'(acked));
    check("rnd_busy", 32'(busy_o), 32'(e_busy));
    if (e_busy) begin
      check("rnd_owner", 32'(owner_o), 32'(m_owner));
      check("rnd_wdata", 32'(wdata), 32'(ds[m_owner]));
    end
    check("rnd_count", 32'(wr_count_o), 32'(m_count));
    check("rnd_err", 32'(err_ovf_o), 32'(m_err));
    if (rst) begin
      m_busy = 0; m_owner = 0; m_words = 0; m_ptr = 0; m_count = '0; m_err = 0;
    end else begin
      if (overflow) m_err = 1;
      if (e_wen) begin
        m_count++;
        m_words++;
      end
      if (!m_busy) begin
        w = scan(req_i, m_ptr, -1);
        if (w >= 0) begin m_busy = 1; m_owner = w; m_words = 0; end
      end else begin
        done = e_wen && (m_words == MB);
        if (!req_i[m_owner] || done) begin
          m_ptr = (m_owner + 1) % N;
          w = scan(req_i, m_ptr, done ? m_owner : -1);
          if (w >= 0) begin m_owner = w; m_words = 0; end
          else m_busy = 0;
        end
      end
    end
  endtask

  initial begin
    int cnt [N];
    int n_acked;
    logic [N-1:0] pa, nreq;
    logic r, f, o;

    rst = 1'b1; req_i = '0; full = 1'b0; overflow = 1'b0; data_i = '0;
    for (int k = 0; k < N; k++) begin ds[k] = '0; cnt[k] = 0; end

    // Row order: round-robin over all four, full stall on requester 2, idle, early release.
    tbl[0] = mk(4'hF, 0, 0, 0, 4'h0, 0, 0, 8'h00, 0);
    tbl[1] = mk(4'hF, 0, 0, 1, 4'h1, 1, 0, 8'h00, 0);
    tbl[2] = mk(4'hF, 0, 0, 1, 4'h1, 1, 0, 8'h01, 0);
    tbl[3] = mk(4'hF, 0, 0, 1, 4'h1, 1, 0, 8'h02, 0);
    tbl[4] = mk(4'hF, 0, 0, 1, 4'h1, 1, 0, 8'h03, 0);
    tbl[5] = mk(4'hF, 0, 1, 1, 4'h2, 1, 1, 8'h10, 0);
    tbl[6] = mk(4'hF, 0, 0, 1, 4'h2, 1, 1, 8'h11, 1);
    tbl[7] = mk(4'hF, 0, 0, 1, 4'h2, 1, 1, 8'h12, 1);
    tbl[8] = mk(4'hF, 0, 0, 1, 4'h2, 1, 1, 8'h13, 1);
    tbl[9] = mk(4'hF, 0, 0, 1, 4'h4, 1, 2, 8'h20, 1);
    for (int i = 10; i < 15; i++) tbl[i] = mk(4'hF, 1, 0, 0, 4'h0, 1, 2, 8'h21, 1);
    tbl[15] = mk(4'hF, 0, 0, 1, 4'h4, 1, 2, 8'h21, 1);
    tbl[16] = mk(4'hF, 0, 0, 1, 4'h4, 1, 2, 8'h22, 1);
    tbl[17] = mk(4'hF, 0, 0, 1, 4'h4, 1, 2, 8'h23, 1);
    tbl[18] = mk(4'hF, 0, 0, 1, 4'h8, 1, 3, 8'h30, 1);
    tbl[19] = mk(4'hF, 0, 0, 1, 4'h8, 1, 3, 8'h31, 1);
    tbl[20] = mk(4'h0, 0, 0, 0, 4'h0, 1, 3, 8'h32, 1);
    tbl[21] = mk(4'h2, 0, 0, 0, 4'h0, 0, 0, 8'h00, 1);
    tbl[22] = mk(4'hB, 0, 0, 1, 4'h2, 1, 1, 8'h14, 1);
    tbl[23] = mk(4'hB, 0, 0, 1, 4'h2, 1, 1, 8'h15, 1);
    tbl[24] = mk(4'h9, 0, 0, 0, 4'h0, 1, 1, 8'h16, 1);
    tbl[25] = mk(4'h9, 0, 0, 1, 4'h8, 1, 3, 8'h32, 1);

    // Reset: port quiet while rst is high.
    drive(1'b1, 4'hF, 1'b0, 1'b0);
    check("rst_wen", 32'(wen), 32'd0);
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    drive(1'b1, 4'h0, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    check("rst_count", 32'(wr_count_o), 32'd0);
    check("rst_err", 32'(err_ovf_o), 32'd0);
    check("rst_owner", 32'(owner_o), 32'd0);

    n_acked = 0;
    for (int r_i = 0; r_i < 26; r_i++) begin
      for (int k = 0; k < N; k++) ds[k] = W'((k << 4) | (cnt[k] & 15));
      drive(tbl[r_i].rst, tbl[r_i].req, tbl[r_i].full, tbl[r_i].ovf);
      check($sformatf("tbl%0d_wen", r_i), 32'(wen), 32'(tbl[r_i].wen));
      check($sformatf("tbl%0d_ack", r_i), 32'(ack_o), 32'(tbl[r_i].ack));
      check($sformatf("tbl%0d_busy", r_i), 32'(busy_o), 32'(tbl[r_i].busy));
      check($sformatf("tbl%0d_err", r_i), 32'(err_ovf_o), 32'(tbl[r_i].err));
      if (tbl[r_i].busy) begin
        check($sformatf("tbl%0d_owner", r_i), 32'(owner_o), 32'(tbl[r_i].owner));
        check($sformatf("tbl%0d_wdata", r_i), 32'(wdata), 32'(tbl[r_i].wdata));
      end
      for (int k = 0; k < N; k++) if (tbl[r_i].ack[k]) begin cnt[k]++; n_acked++; end
    end
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    check("tbl_count", 32'(wr_count_o), 32'(n_acked));

    // Reset mid-burst: requester 0 at beat 2, then rst aborts with no write.
    drive(1'b1, 4'h0, 1'b0, 1'b0);
    drive(1'b0, 4'h1, 1'b0, 1'b0);
    drive(1'b0, 4'h1, 1'b0, 1'b0);
    drive(1'b0, 4'h1, 1'b0, 1'b0);
    drive(1'b1, 4'h1, 1'b0, 1'b0);
    check("midrst_wen", 32'(wen), 32'd0);
    check("midrst_ack", 32'(ack_o), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    check("midrst_busy_after", 32'(busy_o), 32'd0);
    check("midrst_count", 32'(wr_count_o), 32'd0);
    check("midrst_err", 32'(err_ovf_o), 32'd0);

    // Single requester: MAX_BURST writes, one bubble, repeat.
    for (int c = 0; c < 15; c++) begin
      drive(1'b0, 4'h1, 1'b0, 1'b0);
      check($sformatf("single_wen_c%0d", c), 32'(wen), 32'((c % 5) != 0));
    end
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    check("single_count", 32'(wr_count_o), 32'd12);

    // Overflow sticky until reset.
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 4'h0, 1'b0, 1'b0);
      check("ovf_sticky", 32'(err_ovf_o), 32'd1);
    end
    drive(1'b1, 4'h0, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    check("ovf_cleared", 32'(err_ovf_o), 32'd0);

    // Randomized run against the model.
    pa = '0;
    for (int it = 0; it < 800; it++) begin
      r = (it == 0) || ($urandom_range(99) == 0);
      for (int k = 0; k < N; k++) begin
        if (req_i[k]) begin
          if (pa[k]) begin
            nreq[k] = ($urandom_range(3) != 0);
            ds[k]   = W'($urandom);
          end else begin
            nreq[k] = ($urandom_range(39) != 0);
          end
        end else begin
          nreq[k] = ($urandom_range(2) == 0);
          ds[k]   = W'($urandom);
        end
      end
      f = ($urandom_range(3) == 0);
      o = ($urandom_range(49) == 0);
      drive(r, nreq, f, o);
      model_step(pa);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
